// File: rtl/rom_init_pkg.sv
// rom_init_pkg: shared state type, default parameters and helpers for rom_init_rd
package rom_init_pkg;
   typedef enum logic {ST_INIT, ST_READY} state_e;
   localparam int DEF_DATA_W    = 4;
   localparam int DEF_DEPTH     = 8;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_INIT_STEP = 2;
   function automatic logic [31:0] init_val(input logic [31:0] i, input logic [31:0] step, input int w);
      logic [31:0] p;
      p = i * step;
      return (w >= 32) ? p : (p & ((32'd1 << w) - 32'd1));
   endfunction
   function automatic bit params_ok(input int dw, input int depth, input int aw);
      return (dw >= 1) && (depth >= 2) && (aw >= 1) && ((aw >= 31) || ((1 << aw) >= depth));
   endfunction
endpackage

// File: rtl/rom_init_seq.sv
// rom_init_seq: init sequencer FSM, walks every entry once after reset or re-init request
module rom_init_seq
   import rom_init_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int INIT_STEP = DEF_INIT_STEP,
   parameter int CNT_W     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_req_i,
   output logic              ready_o,
   output logic              init_we_o,
   output logic [CNT_W-1:0]  init_addr_o,
   output logic [DATA_W-1:0] init_data_o
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);
   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ready_q;
   logic             start;
   assign start       = ready_q && init_req_i;
   assign ready_o     = ready_q;
   assign init_we_o   = (state_q == ST_INIT) || start;
   assign init_addr_o = cnt_q;
   assign init_data_o = DATA_W'(init_val(32'(cnt_q), 32'(INIT_STEP), DATA_W));
   // Restart writes entry 0 on the request edge, so the counter resumes at 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
      end else if (state_q == ST_INIT) begin
         state_q <= (cnt_q == LAST) ? ST_READY : ST_INIT;
         cnt_q   <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end else begin
         ready_q <= !start;
         state_q <= start ? ST_INIT : ST_READY;
         cnt_q   <= start ? CNT_W'(1) : '0;
      end
   end
endmodule

// File: rtl/rom_init_rd.sv
// rom_init_rd: self-initialising lookup table with registered read port; ROM_WR_EN adds a write port
module rom_init_rd
   import rom_init_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int INIT_STEP = DEF_INIT_STEP
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_req,
   output logic              ready,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err
`ifdef ROM_WR_EN
   ,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
`endif
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam bit PARAMS_OK = params_ok(DATA_W, DEPTH, ADDR_W);
   if (!PARAMS_OK) begin : g_bad_params
      $error("rom_init_rd: illegal parameter combination");
   end
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              init_we;
   logic [IDX_W-1:0]  init_addr;
   logic [DATA_W-1:0] init_data;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              rd_acc;
   logic              rd_oob;
   logic              rd_valid_q;
   logic              rd_err_q;
   logic [DATA_W-1:0] rd_data_q;
   rom_init_seq #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .INIT_STEP(INIT_STEP),
      .CNT_W    (IDX_W)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_req_i (init_req),
      .ready_o    (ready),
      .init_we_o  (init_we),
      .init_addr_o(init_addr),
      .init_data_o(init_data)
   );
   assign rd_acc = ready && rd_req;
   assign rd_oob = {1'b0, rd_addr} >= (ADDR_W + 1)'(DEPTH);
`ifdef ROM_WR_EN
   logic wr_ok;
   assign wr_ok    = ready && wr_en && ({1'b0, wr_addr} < (ADDR_W + 1)'(DEPTH));
   assign mem_we   = init_we || wr_ok;
   assign mem_addr = init_we ? init_addr : wr_addr[IDX_W-1:0];
   assign mem_data = init_we ? init_data : wr_data;
`else
   assign mem_we   = init_we;
   assign mem_addr = init_addr;
   assign mem_data = init_data;
`endif
   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign rd_err   = rd_err_q;
   // Storage: init sequencer owns the port while initialising, user writes only when ready
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_addr] <= mem_data;
   end
   // Read pipeline: one request per cycle, data held between pulses, zero on range error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_acc;
         if (rd_acc) begin
            rd_err_q  <= rd_oob;
            rd_data_q <= rd_oob ? '0 : mem_q[rd_addr[IDX_W-1:0]];
         end
      end
   end
endmodule

// File: tb/tb_rom_init_rd.sv
// tb_rom_init_rd: randomized self-checking bench for rom_init_rd (default and 16-entry step-3 instances)
module tb_rom_init_rd;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       init_req_a, rd_req_a, ready_a, rd_valid_a, rd_err_a;
   logic [7:0] rd_addr_a;
   logic [3:0] rd_data_a;
   logic       init_req_b, rd_req_b, ready_b, rd_valid_b, rd_err_b;
   logic [7:0] rd_addr_b;
   logic [3:0] rd_data_b;
`ifdef ROM_WR_EN
   logic       wr_en_a, wr_en_b;
   logic [7:0] wr_addr_a, wr_addr_b;
   logic [3:0] wr_data_a, wr_data_b;
`endif
   int n_checks = 0;
   int n_fail = 0;
   int shadow[8];
   int last_a = 0;

   always #5 clk = ~clk;

   rom_init_rd u_a (
      .clk(clk), .rst_n(rst_n), .init_req(init_req_a), .ready(ready_a),
      .rd_req(rd_req_a), .rd_addr(rd_addr_a), .rd_valid(rd_valid_a),
      .rd_data(rd_data_a), .rd_err(rd_err_a)
`ifdef ROM_WR_EN
      , .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a)
`endif
   );

   rom_init_rd #(.DATA_W(4), .DEPTH(16), .ADDR_W(8), .INIT_STEP(3)) u_b (
      .clk(clk), .rst_n(rst_n), .init_req(init_req_b), .ready(ready_b),
      .rd_req(rd_req_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid_b),
      .rd_data(rd_data_b), .rd_err(rd_err_b)
`ifdef ROM_WR_EN
      , .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
`endif
   );

   // table content after initialisation: i * step, wrapped into 4 bits
   function automatic int ref_entry(int i, int step);
      return (i * step) % 16;
   endfunction

   task automatic model_init;
      for (int i = 0; i < 8; i++) shadow[i] = ref_entry(i, 2);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      init_req_a = 1'b0; rd_req_a = 1'b0; rd_addr_a = '0;
      init_req_b = 1'b0; rd_req_b = 1'b0; rd_addr_b = '0;
`ifdef ROM_WR_EN
      wr_en_a = 1'b0; wr_addr_a = '0; wr_data_a = '0;
      wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (ready_a !== 1'b0 || rd_valid_a !== 1'b0 || rd_data_a !== 4'd0 || rd_err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: ready=%b valid=%b data=%0d err=%b, need 0 0 0 0", ready_a, rd_valid_a, rd_data_a, rd_err_a);
      end
      rd_req_a = 1'b1;
      rd_addr_a = 8'($urandom_range(0, 7));
      rst_n = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         tick;
         n_checks++;
         if (ready_a !== (k == 8) || rd_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_timing cycle %0d: ready=%b valid=%b, need ready=%b valid=0", k, ready_a, rd_valid_a, k == 8);
         end
         rd_addr_a = 8'($urandom_range(0, 7));
      end
      rd_req_a = 1'b0;
      model_init();
      last_a = 0;
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 8; i++) begin
         rd_req_a = 1'b1;
         rd_addr_a = 8'(i);
         tick;
         n_checks++;
         if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(shadow[i]) || rd_err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back addr %0d: valid=%b data=%0d err=%b, need 1 %0d 0", i, rd_valid_a, rd_data_a, rd_err_a, shadow[i]);
         end
      end
      rd_req_a = 1'b0;
      last_a = shadow[7];
      tick;
      n_checks++;
      if (rd_valid_a !== 1'b0 || rd_data_a !== 4'(last_a)) begin
         n_fail++;
         $display("FAIL idle_hold: valid=%b data=%0d, need 0 %0d", rd_valid_a, rd_data_a, last_a);
      end
   endtask

   task automatic test_out_of_range;
      int addrs[4] = '{8, 255, 9, 7};
      for (int i = 0; i < 4; i++) begin
         rd_req_a = 1'b1;
         rd_addr_a = 8'(addrs[i]);
         tick;
         last_a = (addrs[i] < 8) ? shadow[addrs[i]] : 0;
         n_checks++;
         if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(last_a) || rd_err_a !== (addrs[i] >= 8)) begin
            n_fail++;
            $display("FAIL out_of_range addr %0d: valid=%b data=%0d err=%b, need 1 %0d %b", addrs[i], rd_valid_a, rd_data_a, rd_err_a, last_a, addrs[i] >= 8);
         end
      end
      rd_req_a = 1'b0;
   endtask

   task automatic test_random_reads;
      for (int n = 0; n < 60; n++) begin
         bit req;
         int addr;
         req = ($urandom_range(0, 3) != 0);
         addr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
         rd_req_a = req;
         rd_addr_a = 8'(addr);
         tick;
         if (req) last_a = (addr < 8) ? shadow[addr] : 0;
         n_checks++;
         if (rd_valid_a !== req || rd_data_a !== 4'(last_a) || (req && rd_err_a !== (addr >= 8))) begin
            n_fail++;
            $display("FAIL random_read n=%0d addr %0d req %b: valid=%b data=%0d err=%b, need data %0d err %b", n, addr, req, rd_valid_a, rd_data_a, rd_err_a, last_a, addr >= 8);
         end
      end
      rd_req_a = 1'b0;
   endtask

`ifdef ROM_WR_EN
   task automatic test_write;
      wr_en_a = 1'b1; wr_addr_a = 8'd3; wr_data_a = 4'hF;
      rd_req_a = 1'b1; rd_addr_a = 8'd3;
      tick;
      n_checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(shadow[3])) begin
         n_fail++;
         $display("FAIL write_same_cycle_old: valid=%b data=%0d, need 1 %0d", rd_valid_a, rd_data_a, shadow[3]);
      end
      shadow[3] = 15;
      wr_addr_a = 8'd9; wr_data_a = 4'd5;
      tick;
      n_checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(shadow[3])) begin
         n_fail++;
         $display("FAIL write_new_data: valid=%b data=%0d, need 1 %0d", rd_valid_a, rd_data_a, shadow[3]);
      end
      wr_en_a = 1'b0;
      rd_addr_a = 8'd1;
      tick;
      n_checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(shadow[1])) begin
         n_fail++;
         $display("FAIL write_oob_ignored: data=%0d, need %0d", rd_data_a, shadow[1]);
      end
      last_a = shadow[1];
      rd_req_a = 1'b0;
   endtask
`endif

   task automatic test_reinit;
      rd_req_a = 1'b1; rd_addr_a = 8'd3; init_req_a = 1'b1;
      tick;
      init_req_a = 1'b0;
      last_a = shadow[3];
      n_checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(last_a) || ready_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reinit_read_pre: valid=%b data=%0d ready=%b, need 1 %0d 0", rd_valid_a, rd_data_a, ready_a, last_a);
      end
      for (int k = 1; k <= 8; k++) begin
         rd_req_a = 1'b1;
         rd_addr_a = 8'($urandom_range(0, 7));
         init_req_a = (k == 3);
`ifdef ROM_WR_EN
         wr_en_a = (k == 6); wr_addr_a = 8'd1; wr_data_a = 4'd9;
`endif
         tick;
         n_checks++;
         if (ready_a !== (k == 8) || rd_valid_a !== 1'b0 || rd_data_a !== 4'(last_a)) begin
            n_fail++;
            $display("FAIL reinit_timing cycle %0d: ready=%b valid=%b data=%0d, need ready=%b valid=0 data=%0d", k, ready_a, rd_valid_a, rd_data_a, k == 8, last_a);
         end
      end
      init_req_a = 1'b0;
      rd_req_a = 1'b0;
`ifdef ROM_WR_EN
      wr_en_a = 1'b0;
`endif
      model_init();
   endtask

   task automatic test_reset_mid_init;
      rd_req_a = 1'b1; rd_addr_a = 8'd7; init_req_a = 1'b1;
      tick;
      rd_req_a = 1'b0; init_req_a = 1'b0;
      n_checks++;
      if (rd_valid_a !== 1'b1 || rd_data_a !== 4'(shadow[7])) begin
         n_fail++;
         $display("FAIL mid_read_data: valid=%b data=%0d, need 1 %0d", rd_valid_a, rd_data_a, shadow[7]);
      end
      repeat (4) tick;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (ready_a !== 1'b0 || rd_valid_a !== 1'b0 || rd_data_a !== 4'd0 || rd_err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset_mid_init: ready=%b valid=%b data=%0d err=%b, need 0 0 0 0", ready_a, rd_valid_a, rd_data_a, rd_err_a);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         tick;
         n_checks++;
         if (ready_a !== (k == 8)) begin
            n_fail++;
            $display("FAIL reset_restart_timing cycle %0d: ready=%b, need %b", k, ready_a, k == 8);
         end
      end
      model_init();
      last_a = 0;
   endtask

   task automatic test_param_instance;
      int addrs[6] = '{6, 15, 16, 0, 9, 255};
      int t = 0;
      int exp_d;
      while (ready_b !== 1'b1 && t < 60) begin
         tick;
         t++;
      end
      n_checks++;
      if (ready_b !== 1'b1) begin
         n_fail++;
         $display("FAIL param_ready_timeout: ready=%b, need 1", ready_b);
      end
      for (int n = 0; n < 26; n++) begin
         int a;
         a = (n < 6) ? addrs[n] : int'($urandom_range(0, 15));
         rd_req_b = 1'b1;
         rd_addr_b = 8'(a);
         tick;
         exp_d = (a < 16) ? ref_entry(a, 3) : 0;
         n_checks++;
         if (rd_valid_b !== 1'b1 || rd_data_b !== 4'(exp_d) || rd_err_b !== (a >= 16)) begin
            n_fail++;
            $display("FAIL param_read addr %0d: valid=%b data=%0d err=%b, need 1 %0d %b", a, rd_valid_b, rd_data_b, rd_err_b, exp_d, a >= 16);
         end
      end
      rd_req_b = 1'b0;
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_out_of_range();
      test_random_reads();
`ifdef ROM_WR_EN
      test_write();
`endif
      test_reinit();
      test_back_to_back();
      test_reset_mid_init();
      test_back_to_back();
      test_random_reads();
      test_param_instance();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 time units");
      $fatal(1, "watchdog expired");
   end
endmodule
